// File: rtl/rcu_pkg.sv
// Shared constants for the RCU rename stage: default index widths, lane count
// and the reserved physical register.
package rcu_pkg;

  localparam int ARCH_REG_NUM   = 32;
  localparam int ARCH_REG_WIDTH = 5;
  localparam int PHY_REG_WIDTH  = 5;
  localparam int LANES          = 2;
  localparam int RAT_RD_PORTS   = 3 * LANES;

  localparam logic [PHY_REG_WIDTH-1:0] PREG_ZERO = '0;

endpackage

// File: rtl/rcu_rat_bank.sv
// Register alias table bank: combinational lookups, per-lane writes with the
// higher lane winning, and a whole-table load that overrides the writes.
module rcu_rat_bank
  import rcu_pkg::*;
#(
  parameter int ENTRIES = ARCH_REG_NUM,
  parameter int AW      = ARCH_REG_WIDTH,
  parameter int PW      = PHY_REG_WIDTH,
  parameter int NRD     = RAT_RD_PORTS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NRD-1:0][AW-1:0]         raddr_i,
  output logic [NRD-1:0][PW-1:0]         rdata_o,
  input  logic [LANES-1:0]               we_i,
  input  logic [LANES-1:0][AW-1:0]       waddr_i,
  input  logic [LANES-1:0][PW-1:0]       wdata_i,
  input  logic                           load_i,
  input  logic [ENTRIES-1:0][PW-1:0]     load_tbl_i,
  output logic [ENTRIES-1:0][PW-1:0]     tbl_d_o
);

  logic [ENTRIES-1:0][PW-1:0] tbl_q;
  logic [ENTRIES-1:0][PW-1:0] tbl_d;

  // Ascending lane order lets lane1 overwrite lane0 on the same arch reg.
  always_comb begin
    tbl_d = tbl_q;
    if (load_i) begin
      tbl_d = load_tbl_i;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (we_i[l] && (waddr_i[l] != '0)) begin
          tbl_d[waddr_i[l]] = wdata_i[l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_q <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata_o[i] = (raddr_i[i] == '0) ? '0 : tbl_q[raddr_i[i]];
    end
  end

  assign tbl_d_o = tbl_d;

endmodule

// File: rtl/rcu_rename_table.sv
// Two-lane rename stage: allocates destination pregs from the freelist, keeps
// speculative and committed alias tables, and recycles old pregs on commit.
module rcu_rename_table
  import rcu_pkg::*;
#(
  parameter int ARCH_REG_NUM   = rcu_pkg::ARCH_REG_NUM,
  parameter int ARCH_REG_WIDTH = rcu_pkg::ARCH_REG_WIDTH,
  parameter int PHY_REG_WIDTH  = rcu_pkg::PHY_REG_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 excep_i,
  input  logic [LANES-1:0]                     in_valid_i,
  output logic                                 in_ready_o,
  input  logic [LANES-1:0][ARCH_REG_WIDTH-1:0] rs1_i,
  input  logic [LANES-1:0][ARCH_REG_WIDTH-1:0] rs2_i,
  input  logic [LANES-1:0][ARCH_REG_WIDTH-1:0] rd_i,
  input  logic [LANES-1:0]                     rd_valid_i,
  input  logic [PHY_REG_WIDTH:0]               fl_num_i,
  output logic                                 fl_rd_first_en_o,
  output logic                                 fl_rd_second_en_o,
  input  logic [PHY_REG_WIDTH-1:0]             fl_rdata_first_i,
  input  logic [PHY_REG_WIDTH-1:0]             fl_rdata_second_i,
  output logic [LANES-1:0]                     out_valid_o,
  input  logic                                 out_ready_i,
  output logic [LANES-1:0][PHY_REG_WIDTH-1:0]  prs1_o,
  output logic [LANES-1:0][PHY_REG_WIDTH-1:0]  prs2_o,
  output logic [LANES-1:0][PHY_REG_WIDTH-1:0]  prd_o,
  output logic [LANES-1:0][PHY_REG_WIDTH-1:0]  old_prd_o,
  input  logic [LANES-1:0]                     cm_valid_i,
  input  logic [LANES-1:0][ARCH_REG_WIDTH-1:0] cm_rd_i,
  input  logic [LANES-1:0][PHY_REG_WIDTH-1:0]  cm_prd_i,
  input  logic [LANES-1:0][PHY_REG_WIDTH-1:0]  cm_old_prd_i,
  output logic                                 fl_wr_first_en_o,
  output logic                                 fl_wr_second_en_o,
  output logic [PHY_REG_WIDTH-1:0]             fl_wdata_first_o,
  output logic [PHY_REG_WIDTH-1:0]             fl_wdata_second_o,
  output logic                                 fl_rd_excep_first_en_o,
  output logic                                 fl_rd_excep_second_en_o
);

  localparam int PW = PHY_REG_WIDTH;
  localparam int AW = ARCH_REG_WIDTH;

  logic [LANES-1:0]                need;
  logic [PW:0]                     need_cnt;
  logic                            accept;
  logic [RAT_RD_PORTS-1:0][AW-1:0] srat_raddr;
  logic [RAT_RD_PORTS-1:0][PW-1:0] srat_rdata;
  logic [ARCH_REG_NUM-1:0][PW-1:0] crat_tbl_d;
  logic [ARCH_REG_NUM-1:0][PW-1:0] srat_tbl_unused;
  logic [RAT_RD_PORTS-1:0][PW-1:0] crat_rdata_unused;
  logic [LANES-1:0]                cm_we;

  logic [LANES-1:0][PW-1:0] prs1_d, prs2_d, prd_d, old_prd_d;
  logic [LANES-1:0][PW-1:0] prs1_q, prs2_q, prd_q, old_prd_q;
  logic [LANES-1:0]         out_valid_q;
  logic                     fl_wr_first_en_q, fl_wr_second_en_q;
  logic [PW-1:0]            fl_wdata_first_q, fl_wdata_second_q;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      need[l]  = in_valid_i[l] & rd_valid_i[l] & (rd_i[l] != '0);
      cm_we[l] = cm_valid_i[l] & (cm_rd_i[l] != '0);
    end
  end

  assign need_cnt = (PW + 1)'(need[0]) + (PW + 1)'(need[1]);

  // The whole group stalls unless every allocating lane can be covered.
  assign accept = rst_n & (|in_valid_i) & (~|out_valid_q | out_ready_i)
                & (need_cnt <= fl_num_i) & ~excep_i;

  assign in_ready_o        = accept;
  assign fl_rd_first_en_o  = accept & need[0];
  assign fl_rd_second_en_o = accept & need[1];

  assign srat_raddr = {rd_i[1], rs2_i[1], rs1_i[1], rd_i[0], rs2_i[0], rs1_i[0]};

  rcu_rat_bank #(
    .ENTRIES (ARCH_REG_NUM),
    .AW      (AW),
    .PW      (PW),
    .NRD     (RAT_RD_PORTS)
  ) u_srat (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr_i    (srat_raddr),
    .rdata_o    (srat_rdata),
    .we_i       ({accept & need[1], accept & need[0]}),
    .waddr_i    (rd_i),
    .wdata_i    (prd_d),
    .load_i     (excep_i),
    .load_tbl_i (crat_tbl_d),
    .tbl_d_o    (srat_tbl_unused)
  );

  rcu_rat_bank #(
    .ENTRIES (ARCH_REG_NUM),
    .AW      (AW),
    .PW      (PW),
    .NRD     (RAT_RD_PORTS)
  ) u_crat (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr_i    (srat_raddr),
    .rdata_o    (crat_rdata_unused),
    .we_i       (cm_we),
    .waddr_i    (cm_rd_i),
    .wdata_i    (cm_prd_i),
    .load_i     (1'b0),
    .load_tbl_i ('0),
    .tbl_d_o    (crat_tbl_d)
  );

  // Lane1 sees lane0's fresh allocation instead of the stale table entry.
  always_comb begin
    prs1_d[0]    = srat_rdata[0];
    prs2_d[0]    = srat_rdata[1];
    prd_d[0]     = need[0] ? fl_rdata_first_i : '0;
    old_prd_d[0] = need[0] ? srat_rdata[2] : '0;

    prs1_d[1]    = (need[0] && (rs1_i[1] == rd_i[0])) ? prd_d[0] : srat_rdata[3];
    prs2_d[1]    = (need[0] && (rs2_i[1] == rd_i[0])) ? prd_d[0] : srat_rdata[4];
    prd_d[1]     = need[1] ? fl_rdata_second_i : '0;
    old_prd_d[1] = '0;
    if (need[1]) begin
      old_prd_d[1] = (need[0] && (rd_i[1] == rd_i[0])) ? prd_d[0] : srat_rdata[5];
    end
  end

  // ---- rename output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= '0;
    end else if (excep_i) begin
      out_valid_q <= '0;
    end else if (accept) begin
      out_valid_q <= in_valid_i;
    end else if (out_ready_i) begin
      out_valid_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      prs1_q    <= prs1_d;
      prs2_q    <= prs2_d;
      prd_q     <= prd_d;
      old_prd_q <= old_prd_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign prs1_o      = prs1_q;
  assign prs2_o      = prs2_q;
  assign prd_o       = prd_q;
  assign old_prd_o   = old_prd_q;

  // ---- commit free register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fl_wr_first_en_q  <= 1'b0;
      fl_wr_second_en_q <= 1'b0;
      fl_wdata_first_q  <= '0;
      fl_wdata_second_q <= '0;
    end else begin
      fl_wr_first_en_q  <= cm_we[0] & (cm_old_prd_i[0] != '0);
      fl_wr_second_en_q <= cm_we[1] & (cm_old_prd_i[1] != '0);
      if (cm_we[0] && (cm_old_prd_i[0] != '0)) begin
        fl_wdata_first_q <= cm_old_prd_i[0];
      end
      if (cm_we[1] && (cm_old_prd_i[1] != '0)) begin
        fl_wdata_second_q <= cm_old_prd_i[1];
      end
    end
  end

  assign fl_wr_first_en_o        = fl_wr_first_en_q;
  assign fl_wr_second_en_o       = fl_wr_second_en_q;
  assign fl_wdata_first_o        = fl_wdata_first_q;
  assign fl_wdata_second_o       = fl_wdata_second_q;
  assign fl_rd_excep_first_en_o  = rst_n & cm_we[0];
  assign fl_rd_excep_second_en_o = rst_n & cm_we[1];

endmodule

// File: doc/rcu_rename_table.md
Name: rcu_rename_table

Overview:
Two-lane register rename stage in the RCU. It sits directly downstream of the physical-register freelist and consumes its two read ports to allocate destination pregs. It maintains a speculative alias table (SRAT) and a committed alias table (CRAT). It returns freed pregs to the freelist's write ports on commit. On an exception it restores the SRAT from the CRAT.

Parameters:
ARCH_REG_NUM, 32, architectural registers (x0 never renamed)
ARCH_REG_WIDTH, 5, arch index width
PHY_REG_WIDTH, 5, preg index width; p0 is reserved and never allocated or freed

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
excep_i  in  1  flush: restore SRAT from CRAT, drop pipeline register
in_valid_i  in  2  lane valid {lane1,lane0}
in_ready_o  out  1  group accepted this cycle
rs1_i, rs2_i, rd_i  in  2xARCH_REG_WIDTH each  arch source/dest per lane
rd_valid_i  in  2  lane writes rd
fl_num_i  in  PHY_REG_WIDTH+1  freelist occupancy
fl_rd_first_en_o, fl_rd_second_en_o  out  1  freelist pops (lane0 / lane1)
fl_rdata_first_i, fl_rdata_second_i  in  PHY_REG_WIDTH  popped pregs
out_valid_o  out  2  renamed lane valid (registered)
out_ready_i  in  1  downstream (ROB/dispatch) accepts
prs1_o, prs2_o, prd_o, old_prd_o  out  2xPHY_REG_WIDTH each  renamed operands
cm_valid_i  in  2  commit lane valid
cm_rd_i  in  2xARCH_REG_WIDTH  committed arch dest
cm_prd_i, cm_old_prd_i  in  2xPHY_REG_WIDTH  committed new / previous mapping
fl_wr_first_en_o, fl_wr_second_en_o  out  1  freelist pushes (registered)
fl_wdata_first_o, fl_wdata_second_o  out  PHY_REG_WIDTH  freed pregs
fl_rd_excep_first_en_o, fl_rd_excep_second_en_o  out  1  freelist committed-pointer advance

Behaviour:
- Reset (rst_n=0 at posedge): all SRAT/CRAT entries = 0 (all arch regs map to p0). out_valid_o=0. All fl_*_en_o=0. fl_wdata_*=0.
- Lane needs a preg iff in_valid & rd_valid & rd!=0. need = popcount over lanes.
- Accept rule: accept = |in_valid_i & (~|out_valid_o | out_ready_i) & need<=fl_num_i & ~excep_i. in_ready_o = accept.
- When the freelist cannot cover the whole group, the whole group stalls. No partial lanes are accepted.
- Pops on accept only. fl_rd_first_en_o = lane0 needs. fl_rd_second_en_o = lane1 needs.
  - Lane0's prd = fl_rdata_first_i.
  - Lane1's prd = fl_rdata_second_i. This holds even when only the second port is enabled.
- Non-allocating lanes get prd=0 and old_prd=0.
- Source lookup: prs = SRAT[rs]; rs==0 gives 0.
- Intra-group bypass for lane1:
  - If lane1 rs1/rs2 equals lane0 rd and lane0 needs, lane1 uses lane0's new prd.
  - If lane1 rd equals lane0 rd and both need, lane1 old_prd = lane0 new prd.
- SRAT write on accept, at the next posedge. Lane1 wins over lane0 on the same rd.
- Outputs are registered with 1-cycle latency.
  - The output register holds while out_valid_o!=0 & ~out_ready_i.
  - out_valid_o clears on out_ready_i with no new accept.
- Commit (independent of rename):
  - For each cm_valid lane with cm_rd!=0: CRAT[cm_rd] <= cm_prd. Lane1 wins over lane0 on the same rd.
  - Matching lane pulses fl_rd_excep_*_en_o combinationally.
  - If cm_old_prd!=0: next cycle fl_wr_*_en_o=1 with fl_wdata_* = cm_old_prd. Old p0 is never pushed.
  - Lane-to-port mapping is fixed: commit lane0 drives the first ports, commit lane1 drives the second ports.
- Exception (excep_i=1): at the next posedge, SRAT <= CRAT next-state, which includes same-cycle commits. out_valid_o <= 0. Same-cycle accept is blocked and no pops occur. Commit frees in that cycle still proceed.
- A reset asserted mid-operation overrides excep_i and commit.

Decomposition:
- rcu_pkg: ARCH_REG_WIDTH and PHY_REG_WIDTH defaults, a lane-count constant of 2, and the preg-zero constant.
- One natural sub-module: rcu_rat_bank. It is a 32-entry table with 6 combinational read ports, 2 write ports (higher lane wins), and a whole-table load from another bank. It is instantiated twice, as SRAT and CRAT.

Test Plan:
- Post-reset, fl_num_i=31; lane0 add x1, lane1 add x2; freelist data 1,2 -> both pops asserted; next cycle prd_o={2,1}, old_prd_o={0,0}, prs all 0.
- Lane0 rd=x3, lane1 rs1=x3 & rd=x3; freelist 5,6 -> lane1 prs1=5, old_prd=5, prd=6; SRAT[3]=6.
- need=2 with fl_num_i=1 -> in_ready_o=0, no pops, no SRAT change; raise fl_num_i to 2 -> accepted.
- Commit lane0 rd=x1 prd=1 old=0; lane1 rd=x2 prd=7 old=4 -> fl_rd_excep both 1; next cycle only fl_wr_second_en_o=1 with wdata=4; CRAT[2]=7.
- SRAT[5]=9, CRAT[5]=3, excep_i=1 with a same-cycle commit of x5 to prd 8 -> SRAT[5]=8 next cycle, out_valid_o=0, no pops.
- out_ready_i=0 for 3 cycles with a valid output -> outputs stable, in_ready_o=0, no pops.
